// File: rtl/mskaes_ks_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_ks_ctrl_pkg
// Brief    : Shared constants for the masked AES-128 key-schedule controller.
// Revision : 1.0 - initial release
// ============================================================================
package mskaes_ks_ctrl_pkg;

    localparam int c_state_w      = 3;
    localparam int c_col_w        = 2;
    localparam int c_round_w      = 4;
    localparam int c_nrounds_def  = 10;
    localparam int c_sbox_lat_def = 4;

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_load     = 3'd1;
    localparam logic [2:0] c_st_sb_issue = 3'd2;
    localparam logic [2:0] c_st_sb_wait  = 3'd3;
    localparam logic [2:0] c_st_col0     = 3'd4;
    localparam logic [2:0] c_st_coln     = 3'd5;
    localparam logic [2:0] c_st_done     = 3'd6;

    // Wait counter only ever holds SBOX_LAT-2, so size it for that value.
    function automatic int lat_cnt_w(input int lat);
        return (lat > 2) ? $clog2(lat - 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mskaes_ks_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_ks_lat_cnt
// Brief    : Loadable saturating down-counter with zero flag (S-box wait).
// Revision : 1.0 - initial release
// ============================================================================
module mskaes_ks_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mskaes_ks_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mskaes_ks_ctrl
// Brief    : Control FSM sequencing masked AES-128 round keys column by column.
// Revision : 1.0 - initial release
// ============================================================================
module mskaes_ks_ctrl
    import mskaes_ks_ctrl_pkg::*;
#(
    parameter int NROUNDS  = c_nrounds_def,
    parameter int SBOX_LAT = c_sbox_lat_def
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 sbox_req,
    input  logic                 sbox_gnt,
    output logic                 rcon_rst,
    output logic                 rcon_update,
    output logic                 rcon_mask,
    output logic [c_col_w-1:0]   col_idx,
    output logic [c_round_w-1:0] round_idx,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic                 col_en,
    output logic                 done
);

    localparam int                   c_lat_w      = lat_cnt_w(SBOX_LAT);
    localparam logic [c_lat_w-1:0]   c_lat_load   = c_lat_w'((SBOX_LAT >= 2) ? SBOX_LAT - 2 : 0);
    localparam logic [c_round_w-1:0] c_last_round = c_round_w'(NROUNDS - 1);
    localparam logic [c_col_w-1:0]   c_last_col   = '1;

    logic [c_state_w-1:0] r_state;
    logic [c_col_w-1:0]   r_col;
    logic [c_round_w-1:0] r_round;
    logic                 w_lat_load;
    logic                 w_lat_dec;
    logic                 w_lat_zero;

    assign w_lat_load = (r_state == c_st_sb_issue) && sbox_gnt;
    assign w_lat_dec  = (r_state == c_st_sb_wait);

    mskaes_ks_lat_cnt #(
        .W (c_lat_w)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_lat_load),
        .i_load_val (c_lat_load),
        .i_dec      (w_lat_dec),
        .o_zero     (w_lat_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_col   <= '0;
            r_round <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_col   <= '0;
                    r_round <= '0;
                    if (start) r_state <= c_st_load;
                end
                c_st_load: r_state <= c_st_sb_issue;
                c_st_sb_issue: begin
                    if (sbox_gnt) r_state <= (SBOX_LAT == 1) ? c_st_col0 : c_st_sb_wait;
                end
                c_st_sb_wait: begin
                    if (w_lat_zero) r_state <= c_st_col0;
                end
                c_st_col0: begin
                    if (rk_ready) begin
                        r_col   <= r_col + 1'b1;
                        r_state <= c_st_coln;
                    end
                end
                c_st_coln: begin
                    if (rk_ready) begin
                        r_col <= r_col + 1'b1;
                        // Column 3 accepted closes the round.
                        if (r_col == c_last_col) begin
                            r_round <= r_round + 1'b1;
                            r_state <= (r_round == c_last_round) ? c_st_done : c_st_sb_issue;
                        end
                    end
                end
                c_st_done: begin
                    r_round <= '0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Everything except col_en/rcon_update is a pure decode of registered state.
    assign busy        = (r_state != c_st_idle);
    assign sbox_req    = (r_state == c_st_sb_issue);
    assign rcon_rst    = (r_state == c_st_idle);
    assign rcon_mask   = (r_state == c_st_col0);
    assign rk_valid    = (r_state == c_st_col0) || (r_state == c_st_coln);
    assign col_en      = rk_valid & rk_ready;
    assign rcon_update = (r_state == c_st_coln) && (r_col == c_last_col) && rk_ready;
    assign done        = (r_state == c_st_done);
    assign col_idx     = r_col;
    assign round_idx   = r_round;

endmodule
`default_nettype wire

// File: tb/tb_mskaes_ks_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mskaes_ks_ctrl
// Brief    : Self-checking bench for mskaes_ks_ctrl against a schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mskaes_ks_ctrl;

    localparam int NR  = 10;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, sbox_gnt, rk_ready;
    logic       busy, sbox_req, rcon_rst, rcon_update, rcon_mask, rk_valid, col_en, done;
    logic [1:0] col_idx;
    logic [3:0] round_idx;

    mskaes_ks_ctrl #(.NROUNDS(NR), .SBOX_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .sbox_req(sbox_req), .sbox_gnt(sbox_gnt), .rcon_rst(rcon_rst),
        .rcon_update(rcon_update), .rcon_mask(rcon_mask), .col_idx(col_idx),
        .round_idx(round_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .col_en(col_en), .done(done)
    );

    always #5 clk = ~clk;

    // Attached round-constant generator driven by the controller.
    logic [7:0] rcon_q;
    logic [7:0] rcon_out;
    always @(posedge clk) begin
        if (rcon_rst) rcon_q <= 8'h01;
        else if (rcon_update) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
    assign rcon_out = rcon_mask ? rcon_q : 8'h00;

    typedef struct { int round; int col; int mask; int upd; int rcon; } hs_t;

    hs_t obs_hs[$];
    int  obs_lat[$];
    int  obs_done_cyc, obs_done_cnt, obs_upd_cnt, obs_stab_viol, obs_req_viol;
    int  obs_timeout, obs_aborted;
    int  gnt_delay[NR];
    int  rdy_delay[NR*4];
    int  n_checks = 0;
    int  n_pass   = 0;

    function automatic int exp_rcon(input int r);
        int tbl[10] = '{1, 2, 4, 8, 16, 32, 64, 128, 27, 54};
        return tbl[r];
    endfunction

    // Reference timing: fixed per-round cost plus every injected stall cycle.
    function automatic int exp_done_cyc();
        int t = 2;
        for (int r = 0; r < NR; r++) begin
            t += LAT + 4 + gnt_delay[r];
            for (int c = 0; c < 4; c++) t += rdy_delay[r*4+c];
        end
        return t;
    endfunction

    task automatic clear_delays();
        for (int r = 0; r < NR; r++) gnt_delay[r] = 0;
        for (int k = 0; k < NR*4; k++) rdy_delay[k] = 0;
    endtask

    // Drives a schedule, holding grant/ready off per the delay tables, and records what it sees.
    task automatic run_sched(input int extra_start, input int abort_round, input int abort_col, input int budget);
        int cyc, h_idx, h_cnt, g_idx, g_cnt, grant_cyc;
        bit pend_lat, prev_stall, prev_req_wait;
        logic [1:0] prev_col;
        logic [3:0] prev_round;
        obs_hs.delete(); obs_lat.delete();
        obs_done_cyc = -1; obs_done_cnt = 0; obs_upd_cnt = 0; obs_stab_viol = 0;
        obs_req_viol = 0; obs_timeout = 0; obs_aborted = 0;
        h_idx = 0; h_cnt = 0; g_idx = 0; g_cnt = 0; grant_cyc = 0;
        pend_lat = 0; prev_stall = 0; prev_req_wait = 0; prev_col = 0; prev_round = 0;
        @(negedge clk);
        start = 1'b1; sbox_gnt = 1'b0; rk_ready = 1'b0; cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_start);
            if (prev_stall && (!rk_valid || col_idx !== prev_col || round_idx !== prev_round)) obs_stab_viol++;
            if (prev_req_wait && !sbox_req) obs_req_viol++;
            if (pend_lat && rk_valid) begin
                obs_lat.push_back(cyc - grant_cyc);
                pend_lat = 0;
            end
            if (done) begin
                obs_done_cnt++;
                obs_done_cyc = cyc;
            end
            if (abort_round >= 0 && rk_valid && int'(round_idx) == abort_round && int'(col_idx) == abort_col) begin
                obs_aborted = 1;
                break;
            end
            if (sbox_req) begin
                sbox_gnt = (g_cnt >= gnt_delay[g_idx % NR]);
                if (sbox_gnt) begin grant_cyc = cyc; pend_lat = 1; g_idx++; g_cnt = 0; end
                else g_cnt++;
            end else begin
                sbox_gnt = 1'($urandom_range(0, 1));
            end
            if (rk_valid) begin
                rk_ready = (h_cnt >= rdy_delay[h_idx % (NR*4)]);
                if (rk_ready) begin h_idx++; h_cnt = 0; end
                else h_cnt++;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
            prev_stall    = rk_valid && !rk_ready;
            prev_req_wait = sbox_req && !sbox_gnt;
            prev_col      = col_idx;
            prev_round    = round_idx;
            #1;
            if (!rk_ready && (col_en || rcon_update)) obs_stab_viol++;
            if (col_en) obs_hs.push_back('{int'(round_idx), int'(col_idx), int'(rcon_mask), int'(rcon_update), int'(rcon_out)});
            if (rcon_update) obs_upd_cnt++;
            if (obs_done_cnt > 0 && cyc >= obs_done_cyc + 4) break;
            if (cyc >= budget) begin obs_timeout = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sbox_gnt = 1'b0; rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sbox_gnt = 1'($urandom_range(0, 1));
            rk_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (rcon_rst !== 1'b1) $display("FAIL reset_rcon_rst: got %b expected 1", rcon_rst);
            else n_pass++;
            n_checks++;
            if ({busy, sbox_req, rcon_update, rcon_mask, rk_valid, col_en, done, col_idx, round_idx} !== 13'd0)
                $display("FAIL reset_outputs: got %b expected all zero",
                         {busy, sbox_req, rcon_update, rcon_mask, rk_valid, col_en, done, col_idx, round_idx});
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_full_schedule();
        int e_done;
        clear_delays();
        e_done = exp_done_cyc();
        run_sched(-1, -1, 0, 400);
        n_checks++;
        if (obs_timeout != 0) $display("FAIL full_timeout: got %0d expected 0", obs_timeout); else n_pass++;
        n_checks++;
        if (obs_done_cyc != e_done || e_done != 82) $display("FAIL full_done_cycle: got %0d expected 82", obs_done_cyc); else n_pass++;
        n_checks++;
        if (obs_hs.size() != NR*4) $display("FAIL full_col_en_count: got %0d expected %0d", obs_hs.size(), NR*4); else n_pass++;
        n_checks++;
        if (obs_upd_cnt != NR) $display("FAIL full_update_count: got %0d expected %0d", obs_upd_cnt, NR); else n_pass++;
        for (int k = 0; k < obs_hs.size() && k < NR*4; k++) begin
            n_checks++;
            if (obs_hs[k].round != k/4 || obs_hs[k].col != k%4 || obs_hs[k].mask != int'(k%4 == 0) ||
                obs_hs[k].upd != int'(k%4 == 3) || obs_hs[k].rcon != ((k%4 == 0) ? exp_rcon(k/4) : 0))
                $display("FAIL full_hs%0d: got r%0d c%0d m%0d u%0d rcon%0h expected r%0d c%0d m%0d u%0d rcon%0h",
                         k, obs_hs[k].round, obs_hs[k].col, obs_hs[k].mask, obs_hs[k].upd, obs_hs[k].rcon,
                         k/4, k%4, int'(k%4 == 0), int'(k%4 == 3), (k%4 == 0) ? exp_rcon(k/4) : 0);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0 || rcon_rst !== 1'b1) $display("FAIL full_back_idle: got busy %b rcon_rst %b expected 0 1", busy, rcon_rst); else n_pass++;
    endtask

    task automatic test_sbox_arb();
        clear_delays();
        gnt_delay[3] = 5;
        run_sched(-1, -1, 0, 400);
        n_checks++;
        if (obs_req_viol != 0) $display("FAIL arb_req_held: got %0d drops expected 0", obs_req_viol); else n_pass++;
        n_checks++;
        if (obs_lat.size() != NR) $display("FAIL arb_grant_count: got %0d expected %0d", obs_lat.size(), NR); else n_pass++;
        for (int r = 0; r < obs_lat.size(); r++) begin
            n_checks++;
            if (obs_lat[r] != LAT) $display("FAIL arb_col0_latency_r%0d: got %0d expected %0d", r, obs_lat[r], LAT); else n_pass++;
        end
        n_checks++;
        if (obs_done_cyc != 87) $display("FAIL arb_done_cycle: got %0d expected 87", obs_done_cyc); else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_delays();
        rdy_delay[2] = 3;
        run_sched(-1, -1, 0, 400);
        n_checks++;
        if (obs_stab_viol != 0) $display("FAIL bp_stable: got %0d violations expected 0", obs_stab_viol); else n_pass++;
        n_checks++;
        if (obs_hs.size() < 3 || obs_hs[2].round != 0 || obs_hs[2].col != 2)
            $display("FAIL bp_hs2: got size %0d expected round 0 col 2 at entry 2", obs_hs.size());
        else n_pass++;
        n_checks++;
        if (obs_done_cyc != 85) $display("FAIL bp_done_cycle: got %0d expected 85", obs_done_cyc); else n_pass++;
    endtask

    task automatic test_ignored_start();
        clear_delays();
        run_sched(40, -1, 0, 400);
        n_checks++;
        if (obs_done_cyc != 82) $display("FAIL start_done_cycle: got %0d expected 82", obs_done_cyc); else n_pass++;
        n_checks++;
        if (obs_done_cnt != 1) $display("FAIL start_done_count: got %0d expected 1", obs_done_cnt); else n_pass++;
        n_checks++;
        if (obs_hs.size() != NR*4) $display("FAIL start_hs_count: got %0d expected %0d", obs_hs.size(), NR*4); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_delays();
        run_sched(-1, 5, 1, 400);
        n_checks++;
        if (obs_aborted != 1) $display("FAIL mid_reached_abort: got %0d expected 1", obs_aborted); else n_pass++;
        n_checks++;
        if (obs_done_cnt != 0) $display("FAIL mid_no_done: got %0d expected 0", obs_done_cnt); else n_pass++;
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rcon_rst !== 1'b1 || {busy, sbox_req, rcon_mask, rk_valid, done, col_idx, round_idx} !== 11'd0)
            $display("FAIL mid_reset_outputs: got rcon_rst %b others %b expected 1 and zero", rcon_rst,
                     {busy, sbox_req, rcon_mask, rk_valid, done, col_idx, round_idx});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        run_sched(-1, -1, 0, 400);
        n_checks++;
        if (obs_hs.size() < 1 || obs_hs[0].round != 0 || obs_hs[0].col != 0 || obs_hs[0].rcon != 1)
            $display("FAIL mid_restart_first: got size %0d expected round 0 col 0 rcon 01", obs_hs.size());
        else n_pass++;
        n_checks++;
        if (obs_done_cyc != 82 || obs_done_cnt != 1)
            $display("FAIL mid_restart_done: got cycle %0d count %0d expected 82 1", obs_done_cyc, obs_done_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int e_done;
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < NR; r++) gnt_delay[r] = $urandom_range(0, 3);
            for (int k = 0; k < NR*4; k++) rdy_delay[k] = $urandom_range(0, 2);
            e_done = exp_done_cyc();
            run_sched(-1, -1, 0, 600);
            n_checks++;
            if (obs_done_cyc != e_done) $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, obs_done_cyc, e_done); else n_pass++;
            n_checks++;
            if (obs_stab_viol != 0 || obs_req_viol != 0)
                $display("FAIL rand%0d_stability: got %0d/%0d expected 0/0", it, obs_stab_viol, obs_req_viol);
            else n_pass++;
            n_checks++;
            if (obs_hs.size() != NR*4 || obs_upd_cnt != NR)
                $display("FAIL rand%0d_counts: got %0d/%0d expected %0d/%0d", it, obs_hs.size(), obs_upd_cnt, NR*4, NR);
            else n_pass++;
            for (int k = 0; k < obs_hs.size() && k < NR*4; k++) begin
                n_checks++;
                if (obs_hs[k].round != k/4 || obs_hs[k].col != k%4 || obs_hs[k].mask != int'(k%4 == 0) ||
                    obs_hs[k].rcon != ((k%4 == 0) ? exp_rcon(k/4) : 0))
                    $display("FAIL rand%0d_hs%0d: got r%0d c%0d m%0d rcon%0h expected r%0d c%0d", it, k,
                             obs_hs[k].round, obs_hs[k].col, obs_hs[k].mask, obs_hs[k].rcon, k/4, k%4);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_schedule();
        test_sbox_arb();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mskaes_ks_ctrl.md
# mskaes_ks_ctrl

Control FSM for the 32-bit masked AES-128 key schedule. It sequences the computation of round keys 1..10 column by column. For each round it requests the shared masked S-box for column 0 (SubWord(RotWord(w3))), waits out the S-box latency, then walks the four key columns through a valid/ready handshake. It drives the round-constant generator's reset, update and output-gate controls so that the non-random rcon sharing is XORed into column 0 only.

## Interface
Parameters:
- NROUNDS, 10, number of round keys produced per key load (AES-128).
- SBOX_LAT, 4, cycles from an accepted S-box request to a valid S-box output; ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a key schedule; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- sbox_req  out  1  key schedule requests the shared S-box this cycle.
- sbox_gnt  in  1  S-box granted to key schedule; sampled only while sbox_req=1.
- rcon_rst  out  1  active-high reset to rcon generator.
- rcon_update  out  1  advance rcon to next value.
- rcon_mask  out  1  gate rcon onto its output sharing (nonzero only when high).
- col_idx  out  2  column currently presented (0..3).
- round_idx  out  4  round key being computed, 0-based (0 ↔ RK1).
- rk_valid  out  1  column col_idx of round round_idx is available.
- rk_ready  in  1  consumer accepts the column.
- col_en  out  1  key register write-enable; equals rk_valid & rk_ready.
- done  out  1  one-cycle pulse after the last column of round NROUNDS-1.

## Operation
- States: IDLE, LOAD, SB_ISSUE, SB_WAIT, COL0, COLN, DONE.
- IDLE: rcon_rst=1. On start, go to LOAD. Counters are cleared.
- LOAD: one cycle. rcon_rst=0. rcon already holds 0x01. Go to SB_ISSUE.
- SB_ISSUE: sbox_req=1 held until sbox_gnt.
  - On grant with SBOX_LAT=1, go to COL0.
  - Otherwise go to SB_WAIT with the wait counter = SBOX_LAT-2.
- SB_WAIT: decrement the counter. At 0, go to COL0.
- COL0: col_idx=0, rcon_mask=1, rk_valid=1. On rk_ready, set col_idx=1 and go to COLN.
- COLN: rk_valid=1, rcon_mask=0. On rk_ready, increment col_idx. When col_idx=3 and rk_ready:
  - Pulse rcon_update=1 and increment round_idx.
  - If round_idx was NROUNDS-1, go to DONE. Otherwise go to SB_ISSUE.
- DONE: done=1 for one cycle, then go to IDLE.
- rk_valid, once high, stays high with stable col_idx/round_idx until rk_ready. No retraction.
- rcon_update fires exactly once per round, in the cycle the column-3 handshake completes. It never fires in IDLE, LOAD or DONE.
- round_idx wraps to 0 on return to IDLE. col_idx wraps from 3 to 0.
- start while busy: ignored, no effect.
- sbox_gnt outside SB_ISSUE: ignored.
- rst_n low in any state:
  - Next edge gives IDLE.
  - All outputs 0 except rcon_rst=1.
  - Counters return to 0.
  - An in-flight round is abandoned and no done is issued.

## Timing
- Reset values: busy=0, sbox_req=0, rcon_rst=1, rcon_update=0, rcon_mask=0, rk_valid=0, col_en=0, done=0, col_idx=0, round_idx=0.
- All outputs are registered-state decodes. No combinational path from rk_ready or sbox_gnt to sbox_req, rk_valid, rcon_mask or the index outputs.
- col_en and rcon_update are combinational in rk_ready.
- Per round with gnt/ready always high: SBOX_LAT+4 cycles.
- start sampled at cycle 0:
  - LOAD at cycle 1.
  - First SB_ISSUE at cycle 2.
  - done at cycle 2+NROUNDS·(SBOX_LAT+4), i.e. cycle 82 with defaults.
- Each rk_ready stall cycle adds one cycle. Each cycle of missing grant adds one cycle.

## Structure
- The shared package holds the state encoding (3-bit), the NROUNDS default, the SBOX_LAT default, and the width constants for col_idx/round_idx.
- One sub-module, mskaes_ks_lat_cnt: a loadable down-counter with a zero flag, used for SB_WAIT. The rest of the logic is flat FSM plus the col/round counters.

## Test plan
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles, release with start=0.
  - Required: rcon_rst=1, busy=0, all other outputs 0, held indefinitely.
- Full schedule, defaults, gnt=ready=1:
  - Stimulus: start at cycle 0.
  - Required: done at cycle 82. 40 col_en pulses. 10 rcon_update pulses. rcon_mask high exactly on col_idx=0 handshakes.
  - Required, with rcon generator attached: sampled rcon reads 01,02,04,08,10,20,40,80,1b,36.
- S-box arbitration:
  - Stimulus: hold sbox_gnt=0 for 5 cycles in round 3.
  - Required: sbox_req stays high all 5 cycles. COL0 is entered exactly SBOX_LAT cycles after the granting edge. done slips by 5 cycles.
- Back-pressure:
  - Stimulus: deassert rk_ready for 3 cycles while col_idx=2 in round 0.
  - Required: rk_valid, col_idx=2 and round_idx=0 are stable. col_en=0 and rcon_update=0 during the stall.
- Ignored start:
  - Stimulus: pulse start at cycle 40.
  - Required: no change in sequence, single done at cycle 82.
- Reset mid-operation:
  - Stimulus: rst_n=0 at round_idx=5, col_idx=1, then start again.
  - Required: no done for the aborted run. rcon_rst=1 during reset. New run restarts at round_idx=0 with rcon 0x01 and completes normally.
